seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the 16-bit combinational datapath ALU.
- Keeps the existing 4-bit opcode map and flag set (Cout, lt, eq, gt, V).
- Adds a registered result stage with valid/ready flow control, logical shifts, and an iterative multi-cycle multiplier.
- Sits between the register-file read stage and writeback/memory-address stage; stalls upstream while a multiply is in flight or the result is unconsumed.

Parameters:
- WIDTH, 16, datapath width in bits (≥4, power of two).
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept an operation this cycle.
- opcod  in  4  operation select.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B, also the shift amount via Y[SHW-1:0].
- Cin  in  1  carry-in, used by ADD only.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- out  out  WIDTH  result.
- Cout, V, lt, eq, gt  out  1 each  carry, signed overflow, and signed compare flags of X against Y.

Behaviour:
- Reset, asynchronous while rst_n=0: state=IDLE; out, Cout, V, lt, eq, gt, out_valid all 0; in_ready=0 while rst_n=0.
- Opcode map, with X/Y captured at accept:
  - 0x0 AND
  - 0x1 OR
  - 0x2 ADD: X+Y+Cin
  - 0x3 MUL: low WIDTH bits of unsigned X*Y
  - 0x4 SLL: X<<Y[SHW-1:0]
  - 0x5 SRL: logical X>>Y[SHW-1:0]
  - 0x6 SUB: X+~Y+1, Cin ignored
  - 0x7 SLT: {0…,signed X<Y}
  - 0x8 LW: X+Y
  - 0xA SW: X+Y
  - 0xE BNE: X-Y, eq flag is the branch condition
  - All other opcodes: out=0, flags computed normally.
- Flags:
  - lt/eq/gt are signed compares of X versus Y, valid for every opcode; exactly one is set.
  - Cout is carry-out of the ADD/SUB/LW/SW/BNE adder, and 0 for other ops.
  - For MUL, Cout=1 iff the upper WIDTH product bits are nonzero.
  - V is signed overflow for ADD/SUB/BNE, and 0 otherwise.
- Accept happens when in_valid && in_ready.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
    - Accept of a non-MUL op: result and flags registered, go to HOLD. Latency is 1 cycle.
    - Accept of MUL: load multiplicand, multiplier and product=0; counter=0; go to BUSY.
  - BUSY: in_ready=0, out_valid=0.
    - Each cycle: one shift-add step, which adds the multiplicand if the multiplier LSB is set, shifts the multiplicand left and the multiplier right, then increments the counter.
    - After WIDTH steps, register the result, go to HOLD. MUL latency is WIDTH+1 cycles from accept to out_valid.
    - Early termination is not permitted; latency is fixed.
  - HOLD: out_valid=1; out and flags stable until consumed; in_ready=out_ready (combinational).
    - out_ready && !in_valid: go to IDLE.
    - out_ready && in_valid: accept the new op in the same cycle.
      - Non-MUL: stay in HOLD with the new result, giving back-to-back throughput of 1/cycle.
      - MUL: go to BUSY.
    - !out_ready: hold; new inputs are not accepted.
- Shifts: amounts ≥ WIDTH cannot occur because the amount is SHW bits; amount 0 returns X.
- Reset mid-MUL: the operation is discarded and no result is emitted.
- in_valid while BUSY is ignored; upstream must hold its data.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_AND=4'h0, OP_OR=4'h1, OP_ADD=4'h2, OP_MUL=4'h3, OP_SLL=4'h4, OP_SRL=4'h5, OP_SUB=4'h6, OP_SLT=4'h7, OP_LW=4'h8, OP_SW=4'hA, OP_BNE=4'hE
  - FSM state encoding ST_IDLE/ST_BUSY/ST_HOLD.
- One sub-module, seq_mul_unit, holds the shift-add multiplier:
  - Inputs: start, a, b.
  - Outputs: done, prod_lo, prod_hi_nz.
- Combinational ops stay inline in seq_alu.

Test Plan (WIDTH=16):
- ADD with carry: opcod=2, X=16'hFFFF, Y=16'h0001, Cin=1 -> 1 cycle later out_valid=1, out=16'h0001, Cout=1, V=0, lt=1 (signed -1<1).
- SUB overflow and back-to-back: SUB X=16'h8000, Y=1 -> out=16'h7FFF, V=1, lt=1. Then SLT X=3, Y=5 is accepted in the same HOLD cycle with out_ready=1 -> next cycle out=1.
- MUL latency and stall: opcod=3, X=300, Y=300 -> in_ready=0 for 16 cycles; out_valid on cycle 17; out=16'h5F90, Cout=1. in_valid pulses during BUSY are ignored.
- Backpressure: any result with out_ready=0 for 5 cycles -> out stable, in_ready=0, new in_valid not accepted. Raising out_ready -> consumed, return to IDLE.
- Shifts and illegal opcode: SLL X=16'h0003, Y=16'h0011 -> out=16'h0006 (amount 1). SRL X=16'h8000, Y=15 -> 16'h0001. opcod=4'hF -> out=0.
- Async reset mid-MUL: rst_n low at cycle 5 of BUSY -> out_valid=0 and out=0 immediately. After release: IDLE, in_ready=1, no stale result emitted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map and control-state encoding for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRL = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_SLT = 4'h7;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'hA;
    localparam logic [3:0] OP_BNE = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mul_unit.sv
// Fixed-latency shift-add multiplier: WIDTH steps after start, done pulses with
// the final product presented combinationally so the caller registers it on that edge.
module seq_mul_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic             prod_hi_nz
);

    localparam int SHW = $clog2(WIDTH);

    logic               active;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   mplier;

    always_comb begin
        prod_next = mplier[0] ? prod + mcand : prod;
    end

    assign done       = active && (cnt == SHW'(WIDTH - 1));
    assign prod_lo    = prod_next[WIDTH-1:0];
    assign prod_hi_nz = |prod_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            prod   <= '0;
        end else if (active) begin
            prod   <= prod_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with a registered result stage; single-cycle ops go straight
// to HOLD, MUL runs through the iterative multiplier in BUSY.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcod,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             Cout,
    output logic             V,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    state_t           state;
    logic             accept;
    logic             is_mul;
    logic             sub_op;
    logic             c_in;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             s_lt;
    logic             s_eq;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic             mul_done;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_hi_nz;

    always_comb begin
        case (state)
            ST_IDLE: in_ready = rst_n;
            ST_HOLD: in_ready = rst_n && out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign is_mul = (opcod == OP_MUL);

    // One adder serves ADD/SUB/LW/SW/BNE; subtraction is X + ~Y + 1.
    always_comb begin
        sub_op       = (opcod == OP_SUB) || (opcod == OP_BNE);
        b_op         = sub_op ? ~Y : Y;
        c_in         = sub_op ? 1'b1 : ((opcod == OP_ADD) ? Cin : 1'b0);
        {carry, sum} = {1'b0, X} + {1'b0, b_op} + {{WIDTH{1'b0}}, c_in};
        ovf          = (X[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != X[WIDTH-1]);
        s_lt         = $signed(X) < $signed(Y);
        s_eq         = (X == Y);
    end

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (opcod)
            OP_AND: res = X & Y;
            OP_OR:  res = X | Y;
            OP_SLL: res = X << Y[SHW-1:0];
            OP_SRL: res = X >> Y[SHW-1:0];
            OP_SLT: res = {{(WIDTH-1){1'b0}}, s_lt};
            OP_LW, OP_SW: begin
                res   = sum;
                res_c = carry;
            end
            OP_ADD, OP_SUB, OP_BNE: begin
                res   = sum;
                res_c = carry;
                res_v = ovf;
            end
            default: res = '0;
        endcase
    end

    seq_mul_unit #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (accept && is_mul),
        .a          (X),
        .b          (Y),
        .done       (mul_done),
        .prod_lo    (mul_lo),
        .prod_hi_nz (mul_hi_nz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out       <= '0;
            Cout      <= 1'b0;
            V         <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        // Compare flags are taken at accept since X/Y are not held for MUL.
                        lt <= s_lt;
                        eq <= s_eq;
                        gt <= !s_lt && !s_eq;
                        if (is_mul) begin
                            state     <= ST_BUSY;
                            V         <= 1'b0;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= ST_HOLD;
                            out       <= res;
                            Cout      <= res_c;
                            V         <= res_v;
                            out_valid <= 1'b1;
                        end
                    end else if (state == ST_HOLD && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (mul_done) begin
                        state     <= ST_HOLD;
                        out       <= mul_lo;
                        Cout      <= mul_hi_nz;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16) with hand-computed expectations.
module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcod;
    logic [15:0] X;
    logic [15:0] Y;
    logic        Cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        Cout;
    logic        V;
    logic        lt;
    logic        eq;
    logic        gt;

    int unsigned n_cmp;
    int unsigned n_bad;

    seq_alu #(
        .WIDTH(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcod     (opcod),
        .X         (X),
        .Y         (Y),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .Cout      (Cout),
        .V         (V),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic c);
        in_valid = 1'b1;
        opcod    = op;
        X        = a;
        Y        = b;
        Cin      = c;
    endtask

    task automatic check_flags(input string tag, input logic c, input logic v,
                               input logic l, input logic e, input logic g);
        check({tag, ".Cout"}, {31'd0, Cout}, {31'd0, c});
        check({tag, ".V"},    {31'd0, V},    {31'd0, v});
        check({tag, ".lt"},   {31'd0, lt},   {31'd0, l});
        check({tag, ".eq"},   {31'd0, eq},   {31'd0, e});
        check({tag, ".gt"},   {31'd0, gt},   {31'd0, g});
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcod     = 4'h0;
        X         = '0;
        Y         = '0;
        Cin       = 1'b0;

        #2;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.out", {16'd0, out}, 32'd0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        check("idle.in_ready", {31'd0, in_ready}, 32'd1);

        // ADD with carry-in, then backpressure for 5 cycles
        drive(4'h2, 16'hFFFF, 16'h0001, 1'b1);
        tick();
        check("add.out_valid", {31'd0, out_valid}, 32'd1);
        check("add.out", {16'd0, out}, 32'h0001);
        check_flags("add", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(4'h0, 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp.in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            check("bp.out", {16'd0, out}, 32'h0001);
            check("bp.out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp.release.out_valid", {31'd0, out_valid}, 32'd0);
        check("bp.release.in_ready", {31'd0, in_ready}, 32'd1);

        // SUB overflow, then back-to-back chain from HOLD
        drive(4'h6, 16'h8000, 16'h0001, 1'b1);
        tick();
        check("sub.out", {16'd0, out}, 32'h7FFF);
        check_flags("sub", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("sub.in_ready", {31'd0, in_ready}, 32'd1);
        drive(4'h7, 16'd3, 16'd5, 1'b0);
        tick();
        check("slt.out_valid", {31'd0, out_valid}, 32'd1);
        check("slt.out", {16'd0, out}, 32'h0001);
        check_flags("slt", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(4'h4, 16'h0003, 16'h0011, 1'b0);
        tick();
        check("sll.out", {16'd0, out}, 32'h0006);
        drive(4'h5, 16'h8000, 16'd15, 1'b0);
        tick();
        check("srl.out", {16'd0, out}, 32'h0001);
        drive(4'h4, 16'h1234, 16'h0010, 1'b0);
        tick();
        check("sll0.out", {16'd0, out}, 32'h1234);
        drive(4'hF, 16'd5, 16'd5, 1'b1);
        tick();
        check("ill.out", {16'd0, out}, 32'h0000);
        check_flags("ill", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(4'h2, 16'h7FFF, 16'h0001, 1'b0);
        tick();
        check("addv.out", {16'd0, out}, 32'h8000);
        check_flags("addv", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(4'h8, 16'd10, 16'd20, 1'b1);
        tick();
        check("lw.out", {16'd0, out}, 32'd30);
        check_flags("lw", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(4'hE, 16'd5, 16'd5, 1'b0);
        tick();
        check("bne.out", {16'd0, out}, 32'h0000);
        check_flags("bne", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(4'h0, 16'hF0F0, 16'h3C3C, 1'b0);
        tick();
        check("and.out", {16'd0, out}, 32'h3030);
        drive(4'h1, 16'hF0F0, 16'h0F01, 1'b0);
        tick();
        check("or.out", {16'd0, out}, 32'hFFF1);
        in_valid = 1'b0;
        tick();
        check("chain.idle.out_valid", {31'd0, out_valid}, 32'd0);

        // MUL from IDLE with ignored in_valid pulses during BUSY
        drive(4'h3, 16'd300, 16'd300, 1'b0);
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i < 15) begin
                drive(4'h0, 16'hFFFF, 16'hFFFF, 1'b0);
                in_valid = (i % 2 == 0);
            end else begin
                in_valid = 1'b0;
            end
            check("mul.busy.in_ready", {31'd0, in_ready}, 32'd0);
            check("mul.busy.out_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        check("mul.out_valid", {31'd0, out_valid}, 32'd1);
        check("mul.out", {16'd0, out}, 32'h5F90);
        check_flags("mul", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("mul.consumed", {31'd0, out_valid}, 32'd0);

        // Async reset in the middle of a multiply
        drive(4'h3, 16'd7, 16'd9, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("rstmul.busy", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmul.out_valid", {31'd0, out_valid}, 32'd0);
        check("rstmul.out", {16'd0, out}, 32'h0000);
        check("rstmul.in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rstmul.idle.in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("rstmul.no_stale", {31'd0, out_valid}, 32'd0);
        end

        // MUL accepted straight from HOLD, small product (no high bits)
        drive(4'h2, 16'd1, 16'd2, 1'b0);
        tick();
        check("add2.out", {16'd0, out}, 32'd3);
        drive(4'h3, 16'h00FF, 16'h0101, 1'b0);
        tick();
        in_valid = 1'b0;
        check("mul2.busy.out_valid", {31'd0, out_valid}, 32'd0);
        check("mul2.busy.in_ready", {31'd0, in_ready}, 32'd0);
        repeat (15) tick();
        check("mul2.early", {31'd0, out_valid}, 32'd0);
        tick();
        check("mul2.out_valid", {31'd0, out_valid}, 32'd1);
        check("mul2.out", {16'd0, out}, 32'hFFFF);
        check_flags("mul2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
